cnn_layer_seq: RTL and testbench

Layer sequencer for the CNN engine. It steps each network layer through three phases: convolution, erase of the input memory, and max-pooling back into the input memory. For each phase it issues the one-cycle `conv_en` / `eras_en` / `maxp_en` pulses that the memory-select logic latches, then waits for that engine's done pulse before starting the next phase. It sits between the host start/status interface and the three engines plus the memory select.

---
 rtl/cnn_layer_seq_if.sv | 33 +++
 rtl/cnn_layer_seq.sv | 183 ++++++++++++++++++
 tb/tb_cnn_layer_seq.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_seq_if.sv
// Host/engine-facing signal bundle of the CNN layer sequencer.
// master = host plus engines, slave = the sequencer itself.
interface cnn_layer_seq_if #(
    parameter int LAYER_W    = 4,
    parameter int MAX_LAYERS = 16
);
    logic                  start;
    logic                  abort;
    logic [LAYER_W-1:0]    num_layers;
    logic [MAX_LAYERS-1:0] pool_mask;
    logic                  conv_done;
    logic                  eras_done;
    logic                  maxp_done;
    logic                  conv_en;
    logic                  eras_en;
    logic                  maxp_en;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [LAYER_W-1:0]    layer_idx;

    modport master (
        output start, abort, num_layers, pool_mask,
        output conv_done, eras_done, maxp_done,
        input  conv_en, eras_en, maxp_en, busy, done, err, layer_idx
    );

    modport slave (
        input  start, abort, num_layers, pool_mask,
        input  conv_done, eras_done, maxp_done,
        output conv_en, eras_en, maxp_en, busy, done, err, layer_idx
    );
endinterface

// File: rtl/cnn_layer_seq.sv
// Layer sequencer: per layer runs CONV, then ERAS and MAXP when pooled.
// Optional per-phase watchdog enabled by defining CNN_SEQ_TIMEOUT_EN.
module cnn_layer_seq #(
    parameter int LAYER_W     = 4,
    parameter int MAX_LAYERS  = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic           clk,
    input  logic           rst,
    cnn_layer_seq_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_C_ISS,
        S_C_WT,
        S_E_ISS,
        S_E_WT,
        S_M_ISS,
        S_M_WT,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [LAYER_W-1:0]    layer_q, layer_d;
    logic [LAYER_W-1:0]    nlayers_q, nlayers_d;
    logic [MAX_LAYERS-1:0] mask_q, mask_d;
    logic                  conv_en_q, eras_en_q, maxp_en_q;
    logic                  busy_q, done_q;
    logic                  phase_done;
    state_e                phase_next;
`ifdef CNN_SEQ_TIMEOUT_EN
    logic                  err_q, err_d;
    logic [15:0]           wd_q, wd_d;
`endif

    if (MAX_LAYERS > (1 << LAYER_W) || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("cnn_layer_seq: MAX_LAYERS or TIMEOUT_CYC out of range");
    end

    // The three wait states differ only in which done they listen to and where it leads.
    always_comb begin
        phase_done = 1'b0;
        phase_next = state_q;
        case (state_q)
            S_C_WT: begin
                phase_done = bus.conv_done;
                phase_next = mask_q[layer_q] ? S_E_ISS : S_NEXT;
            end
            S_E_WT: begin
                phase_done = bus.eras_done;
                phase_next = S_M_ISS;
            end
            S_M_WT: begin
                phase_done = bus.maxp_done;
                phase_next = S_NEXT;
            end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d   = state_q;
        layer_d   = layer_q;
        nlayers_d = nlayers_q;
        mask_d    = mask_q;
`ifdef CNN_SEQ_TIMEOUT_EN
        err_d     = err_q;
        wd_d      = wd_q;
`endif
        case (state_q)
            S_IDLE, S_ERR: begin
                if (bus.start) begin
`ifdef CNN_SEQ_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (bus.num_layers == '0) begin
                        state_d = S_DONE;
                    end else begin
                        layer_d   = '0;
                        nlayers_d = bus.num_layers;
                        mask_d    = bus.pool_mask;
                        state_d   = S_C_ISS;
                    end
                end
            end
            S_C_ISS, S_E_ISS, S_M_ISS: begin
                case (state_q)
                    S_C_ISS: state_d = S_C_WT;
                    S_E_ISS: state_d = S_E_WT;
                    default: state_d = S_M_WT;
                endcase
`ifdef CNN_SEQ_TIMEOUT_EN
                wd_d = '0;
`endif
            end
            S_C_WT, S_E_WT, S_M_WT: begin
                if (phase_done) begin
                    state_d = phase_next;
                end
`ifdef CNN_SEQ_TIMEOUT_EN
                else begin
                    wd_d = wd_q + 16'd1;
                    if (wd_d == 16'(TIMEOUT_CYC)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            S_NEXT: begin
                if (layer_q == nlayers_q - 1'b1) begin
                    state_d = S_DONE;
                end else begin
                    layer_d = layer_q + 1'b1;
                    state_d = S_C_ISS;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort beats everything, including a simultaneous start.
        if (bus.abort) begin
            state_d   = S_IDLE;
            layer_d   = layer_q;
            nlayers_d = nlayers_q;
            mask_d    = mask_q;
`ifdef CNN_SEQ_TIMEOUT_EN
            err_d     = err_q;
            wd_d      = wd_q;
`endif
        end
    end

    // Outputs are decoded from the next state so they are registered yet line up with the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            layer_q   <= '0;
            nlayers_q <= '0;
            mask_q    <= '0;
            conv_en_q <= 1'b0;
            eras_en_q <= 1'b0;
            maxp_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
            wd_q      <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout, so every register samples pre-edge values regardless of order.
            state_q   <= state_d;
            layer_q   <= layer_d;
            nlayers_q <= nlayers_d;
            mask_q    <= mask_d;
            conv_en_q <= (state_d == S_C_ISS);
            eras_en_q <= (state_d == S_E_ISS);
            maxp_en_q <= (state_d == S_M_ISS);
            busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
            done_q    <= (state_d == S_DONE);
`ifdef CNN_SEQ_TIMEOUT_EN
            err_q     <= err_d;
            wd_q      <= wd_d;
`endif
        end
    end

    assign bus.conv_en   = conv_en_q;
    assign bus.eras_en   = eras_en_q;
    assign bus.maxp_en   = maxp_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.layer_idx = layer_q;
`ifdef CNN_SEQ_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_cnn_layer_seq.sv
// Scoreboard bench for cnn_layer_seq: expected enable/done events with cycle windows.
// A timed engine model answers each enable with its done pulse 5 cycles later.
module tb_cnn_layer_seq;
    localparam int K_CONV   = 0;
    localparam int K_ERAS   = 1;
    localparam int K_MAXP   = 2;
    localparam int K_DONE   = 3;
    localparam int RESP_DLY = 5;

    typedef struct {
        int kind;
        int layer;
        int lo;
        int hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    logic r_conv = 1'b0, r_eras = 1'b0, r_maxp = 1'b0;
    logic s_conv = 1'b0, s_eras = 1'b0, s_maxp = 1'b0;
    logic resp_on = 1'b1;
    logic hold_eras = 1'b0;

    cnn_layer_seq_if #(.LAYER_W(4), .MAX_LAYERS(16)) bus ();

    cnn_layer_seq #(.LAYER_W(4), .MAX_LAYERS(16), .TIMEOUT_CYC(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.conv_done = r_conv | s_conv;
    assign bus.eras_done = r_eras | s_eras;
    assign bus.maxp_done = r_maxp | s_maxp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push(input int kind, input int layer, input int lo, input int hi);
        exp_t e;
        e.kind  = kind;
        e.layer = layer;
        e.lo    = lo;
        e.hi    = hi;
        sb.push_back(e);
    endtask

    task automatic start_run(input int n, input logic [15:0] mask);
        bus.start      = 1'b1;
        bus.num_layers = 4'(n);
        bus.pool_mask  = mask;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(bus.done), 1);
    endtask

    // Engine model: a done pulse RESP_DLY cycles after the enable it answers.
    initial begin
        int cnt = -1;
        int kind = 0;
        forever begin
            @(negedge clk);
            r_conv = 1'b0;
            r_eras = 1'b0;
            r_maxp = 1'b0;
            if (cnt == 0) begin
                case (kind)
                    K_CONV:  r_conv = 1'b1;
                    K_ERAS:  r_eras = !hold_eras;
                    default: r_maxp = 1'b1;
                endcase
                cnt = -1;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (resp_on && cnt < 0 && rst) begin
                if (bus.conv_en) begin kind = K_CONV; cnt = RESP_DLY - 1; end
                else if (bus.eras_en) begin kind = K_ERAS; cnt = RESP_DLY - 1; end
                else if (bus.maxp_en) begin kind = K_MAXP; cnt = RESP_DLY - 1; end
            end
        end
    end

    // Monitor: every enable or done the DUT shows is matched against the queue.
    initial begin
        exp_t e;
        int kind;
        forever begin
            @(negedge clk);
            if (rst && (bus.conv_en || bus.eras_en || bus.maxp_en || bus.done)) begin
                kind = bus.conv_en ? K_CONV : bus.eras_en ? K_ERAS : bus.maxp_en ? K_MAXP : K_DONE;
                check("one_output_at_a_time",
                      $countones({bus.conv_en, bus.eras_en, bus.maxp_en, bus.done}), 1);
                check("busy_at_event", int'(bus.busy), (kind == K_DONE) ? 0 : 1);
                check("err_at_event", int'(bus.err), 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", kind, e.kind);
                    if (e.layer >= 0) check("event_layer", int'(bus.layer_idx), e.layer);
                    check_rng("event_cycle", cyc, e.lo, e.hi);
                end
            end
        end
    end

    initial begin
        int   b;
        int   y;
        int   n;
        int   done_cnt;
        logic seen;

        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.num_layers = '0;
        bus.pool_mask  = '0;
        repeat (3) @(negedge clk);
        check("rst_conv_en", int'(bus.conv_en), 0);
        check("rst_eras_en", int'(bus.eras_en), 0);
        check("rst_maxp_en", int'(bus.maxp_en), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_layer", int'(bus.layer_idx), 0);
        rst = 1'b1;
        @(negedge clk);

        // Two layers, both pooled.
        b = cyc + 1;
        push(K_CONV, 0, b, b);
        push(K_ERAS, 0, b + 6, b + 6);
        push(K_MAXP, 0, b + 12, b + 12);
        push(K_CONV, 1, b + 19, b + 19);
        push(K_ERAS, 1, b + 25, b + 25);
        push(K_MAXP, 1, b + 31, b + 31);
        push(K_DONE, 1, b + 38, b + 38);
        start_run(2, 16'h0003);
        check("a_conv_en_after_start", int'(bus.conv_en), 1);
        check("a_layer_first", int'(bus.layer_idx), 0);
        wait_done("a_done_seen", 80);
        @(negedge clk);
        check("a_busy_after_done", int'(bus.busy), 0);
        check("a_done_single_cycle", int'(bus.done), 0);
        check("a_layer_held", int'(bus.layer_idx), 1);

        // Back-to-back start, only layer 1 pooled.
        b = cyc + 1;
        push(K_CONV, 0, b, b);
        push(K_CONV, 1, b + 7, b + 7);
        push(K_ERAS, 1, b + 13, b + 13);
        push(K_MAXP, 1, b + 19, b + 19);
        push(K_CONV, 2, b + 26, b + 26);
        push(K_DONE, 2, b + 33, b + 33);
        start_run(3, 16'h0002);
        wait_done("b_done_seen", 80);
        @(negedge clk);

        // Zero layers: done only, busy never raised.
        b = cyc + 1;
        push(K_DONE, -1, b, b + 1);
        start_run(0, 16'h0000);
        seen     = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.busy) seen = 1'b1;
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        check("z_busy_never", int'(seen), 0);
        check("z_done_count", done_cnt, 1);

        // Stray done pulses are ignored.
        resp_on = 1'b0;
        b = cyc + 1;
        push(K_CONV, 0, b, b);
        start_run(1, 16'h0000);
        s_conv = 1'b1;
        @(negedge clk);
        s_conv = 1'b0;
        s_maxp = 1'b1;
        @(negedge clk);
        s_maxp = 1'b0;
        repeat (6) @(negedge clk);
        check("c_still_busy", int'(bus.busy), 1);
        check("c_no_done_yet", int'(bus.done), 0);
        y = cyc;
        push(K_DONE, 0, y + 2, y + 2);
        s_conv = 1'b1;
        @(negedge clk);
        s_conv = 1'b0;
        wait_done("c_done_seen", 10);
        resp_on = 1'b1;
        @(negedge clk);

        // Abort while waiting for eras_done of layer 1.
        b = cyc + 1;
        push(K_CONV, 0, b, b);
        push(K_ERAS, 0, b + 6, b + 6);
        push(K_MAXP, 0, b + 12, b + 12);
        push(K_CONV, 1, b + 19, b + 19);
        push(K_ERAS, 1, b + 25, b + 25);
        start_run(2, 16'h0003);
        n = 0;
        while (!(bus.eras_en && bus.layer_idx == 4'd1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("d_reached_eras1", int'(bus.eras_en), 1);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("d_abort_busy", int'(bus.busy), 0);
        check("d_abort_enables", int'({bus.conv_en, bus.eras_en, bus.maxp_en}), 0);
        check("d_abort_done", int'(bus.done), 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("d_no_done_after_abort", int'(seen), 0);
        b = cyc + 1;
        push(K_CONV, 0, b, b);
        push(K_DONE, 0, b + 7, b + 7);
        start_run(1, 16'h0000);
        check("d_restart_layer0", int'(bus.layer_idx), 0);
        wait_done("d_restart_done", 20);
        @(negedge clk);

        // Reset mid-run while waiting for maxp_done.
        b = cyc + 1;
        push(K_CONV, 0, b, b);
        push(K_ERAS, 0, b + 6, b + 6);
        push(K_MAXP, 0, b + 12, b + 12);
        start_run(2, 16'h0003);
        n = 0;
        while (!bus.maxp_en && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("e_reached_maxp", int'(bus.maxp_en), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("e_rst_enables", int'({bus.conv_en, bus.eras_en, bus.maxp_en}), 0);
        check("e_rst_busy", int'(bus.busy), 0);
        check("e_rst_done", int'(bus.done), 0);
        check("e_rst_err", int'(bus.err), 0);
        check("e_rst_layer", int'(bus.layer_idx), 0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy || bus.done) seen = 1'b1;
        end
        check("e_idle_after_rst", int'(seen), 0);

`ifdef CNN_SEQ_TIMEOUT_EN
        // Withheld eras_done trips the watchdog after 20 wait cycles.
        hold_eras = 1'b1;
        b = cyc + 1;
        push(K_CONV, 0, b, b);
        push(K_ERAS, 0, b + 6, b + 6);
        start_run(1, 16'h0001);
        n = 0;
        while (!bus.err && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("t_err_set", int'(bus.err), 1);
        check_rng("t_err_cycle", cyc, b + 27, b + 27);
        check("t_err_busy", int'(bus.busy), 0);
        hold_eras = 1'b0;
        b = cyc + 1;
        push(K_CONV, 0, b, b);
        push(K_DONE, 0, b + 7, b + 7);
        start_run(1, 16'h0000);
        check("t_err_cleared", int'(bus.err), 0);
        wait_done("t_rerun_done", 20);
        @(negedge clk);
`endif

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
